// File: rtl/stopwatch_pkg.sv
// Shared types and 7-segment decoding for the stopwatch/timer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SET   = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // Active-low segments, bit order gfedcba
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001,
    7'b001_0010, 7'b000_0010, 7'b111_1000, 7'b000_0000, 7'b001_0000
  };

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    if (bcd <= 4'd9) begin
      seg = SEG_DIGIT[bcd];
    end else begin
      seg = SEG_BLANK;
    end
    return seg;
  endfunction

endpackage

// File: rtl/stopwatch_timer_button_conditioner.sv
// Active-low button: 2-FF synchroniser, stable-level debounce, rising-edge press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic btn_ni,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync0_q;
  logic          sync1_q;
  logic          level_q;
  logic          level_prev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // A new level is accepted only after it has differed from the accepted one for the full window
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync0_q      <= 1'b0;
      sync1_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync0_q      <= ~btn_ni;
      sync1_q      <= sync0_q;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      if (sync1_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync1_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_timer.sv
// N-digit BCD stopwatch / countdown timer with alarm and digit-set mode.
// Optional lap display freeze when STOPWATCH_LAP_EN is defined.
module stopwatch_timer #(
  parameter int DIGITS          = 4,
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk100_i,
  input  logic                  rstn_i,
  input  logic                  start_stop_i,
  input  logic                  set_i,
  input  logic                  change_i,
  input  logic                  mode_i,
`ifdef STOPWATCH_LAP_EN
  input  logic                  lap_i,
`endif
  output logic [7*DIGITS-1:0]   hex_o,
  output logic                  running_o,
  output logic                  alarm_o,
  output logic [DIGITS-1:0]     set_sel_o
);
  import stopwatch_pkg::*;

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(PRESCALE);
  localparam int PTRW     = $clog2(DIGITS);

  state_e                  state_q;
  logic [DIGITS-1:0][3:0]  digits_q;
  logic [DIGITS-1:0][3:0]  digits_inc_s;
  logic [DIGITS-1:0][3:0]  digits_dec_s;
  logic [DIGITS-1:0][3:0]  disp_s;
  logic [PW-1:0]           presc_q;
  logic [PTRW-1:0]         ptr_q;
  logic                    mode_q;
  logic                    start_p_s;
  logic                    set_p_s;
  logic                    change_p_s;
  logic                    tick_s;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
    .clk_i(clk100_i), .rstn_i(rstn_i), .btn_ni(start_stop_i), .press_o(start_p_s));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_set (
    .clk_i(clk100_i), .rstn_i(rstn_i), .btn_ni(set_i), .press_o(set_p_s));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_change (
    .clk_i(clk100_i), .rstn_i(rstn_i), .btn_ni(change_i), .press_o(change_p_s));

`ifdef STOPWATCH_LAP_EN
  logic                    lap_p_s;
  logic                    frozen_q;
  logic [DIGITS-1:0][3:0]  snap_q;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
    .clk_i(clk100_i), .rstn_i(rstn_i), .btn_ni(lap_i), .press_o(lap_p_s));
`endif

  assign tick_s = (state_q == ST_RUN) && (presc_q == PW'(PRESCALE - 1));

  // Ripple BCD increment and decrement candidates of the current value
  always_comb begin : p_bcd_step
    logic carry_v;
    logic borrow_v;
    carry_v      = 1'b1;
    borrow_v     = 1'b1;
    digits_inc_s = digits_q;
    digits_dec_s = digits_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry_v) begin
        if (digits_q[i] == 4'd9) begin
          digits_inc_s[i] = 4'd0;
        end else begin
          digits_inc_s[i] = digits_q[i] + 4'd1;
          carry_v         = 1'b0;
        end
      end else begin
        digits_inc_s[i] = digits_q[i];
      end
      if (borrow_v) begin
        if (digits_q[i] == 4'd0) begin
          digits_dec_s[i] = 4'd9;
        end else begin
          digits_dec_s[i] = digits_q[i] - 4'd1;
          borrow_v        = 1'b0;
        end
      end else begin
        digits_dec_s[i] = digits_q[i];
      end
    end
  end

  // Control FSM, time base and prescaler; prescaler only advances in RUN
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      presc_q  <= '0;
      ptr_q    <= '0;
      mode_q   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      frozen_q <= 1'b0;
      snap_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_q <= '0;
          if (start_p_s) begin
            mode_q <= mode_i;
            if (!(mode_i && (digits_q == '0))) begin
              state_q <= ST_RUN;
            end
          end else if (set_p_s) begin
            state_q <= ST_SET;
            ptr_q   <= '0;
          end
        end
        ST_RUN: begin
          if (start_p_s) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
`ifdef STOPWATCH_LAP_EN
            frozen_q <= 1'b0;
`endif
          end else begin
`ifdef STOPWATCH_LAP_EN
            if (lap_p_s) begin
              frozen_q <= ~frozen_q;
              snap_q   <= digits_q;
            end
`endif
            if (tick_s) begin
              presc_q <= '0;
              if (mode_q) begin
                digits_q <= digits_dec_s;
                if (digits_dec_s == '0) begin
                  state_q <= ST_ALARM;
`ifdef STOPWATCH_LAP_EN
                  frozen_q <= 1'b0;
`endif
                end
              end else begin
                digits_q <= digits_inc_s;
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
        end
        ST_SET: begin
          presc_q <= '0;
          if (!start_p_s && set_p_s) begin
            if (ptr_q == PTRW'(DIGITS - 1)) begin
              state_q <= ST_IDLE;
              ptr_q   <= '0;
            end else begin
              ptr_q <= ptr_q + PTRW'(1);
            end
          end else if (!start_p_s && change_p_s) begin
            digits_q[ptr_q] <= (digits_q[ptr_q] == 4'd9) ? 4'd0 : digits_q[ptr_q] + 4'd1;
          end
        end
        ST_ALARM: begin
          presc_q <= '0;
          if (start_p_s || set_p_s || change_p_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          presc_q <= '0;
        end
      endcase
    end
  end

  // Output decode of registered state
  always_comb begin
`ifdef STOPWATCH_LAP_EN
    if (frozen_q) begin
      disp_s = snap_q;
    end else begin
      disp_s = digits_q;
    end
`else
    disp_s = digits_q;
`endif
    hex_o = '1;
    for (int i = 0; i < DIGITS; i++) begin
      hex_o[7*i +: 7] = bcd_to_seg(disp_s[i]);
    end
    running_o = (state_q == ST_RUN);
    alarm_o   = (state_q == ST_ALARM);
    if (state_q == ST_SET) begin
      set_sel_o = DIGITS'(1) << ptr_q;
    end else begin
      set_sel_o = '0;
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Self-checking bench for stopwatch_timer with a decimal-integer reference model.
module tb_stopwatch_timer;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_n, set_n, change_n, lap_n, mode;
  logic [27:0] hex;
  logic        running, alarm;
  logic [3:0]  set_sel;

  int checks = 0;
  int errors = 0;
  int cur_val = 0;

  logic [6:0] seg_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  stopwatch_timer #(
    .DIGITS(DIGITS), .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk100_i(clk), .rstn_i(rstn), .start_stop_i(start_n), .set_i(set_n),
    .change_i(change_n), .mode_i(mode),
`ifdef STOPWATCH_LAP_EN
    .lap_i(lap_n),
`endif
    .hex_o(hex), .running_o(running), .alarm_o(alarm), .set_sel_o(set_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] exp_hex(input int v);
    logic [27:0] h;
    int t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      h[7*i +: 7] = seg_tab[t % 10];
      t = t / 10;
    end
    return h;
  endfunction

  function automatic int dig(input int v, input int i);
    int t;
    t = v;
    for (int k = 0; k < i; k++) t = t / 10;
    return t % 10;
  endfunction

  // Hold the pin low long enough to be accepted, then release and let it settle
  task automatic press(input int which);
    case (which)
      0: start_n = 1'b0;
      1: set_n = 1'b0;
      2: change_n = 1'b0;
      3: lap_n = 1'b0;
      default: ;
    endcase
    repeat (8) @(negedge clk);
    start_n = 1'b1; set_n = 1'b1; change_n = 1'b1; lap_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    cur_val = 0;
  endtask

  task automatic load_value(input int v);
    press(1);
    for (int i = 0; i < DIGITS; i++) begin
      repeat ((dig(v, i) - dig(cur_val, i) + 10) % 10) press(2);
      press(1);
    end
    cur_val = v;
    checks++;
    if (hex !== exp_hex(v) || set_sel !== 4'd0) begin
      errors++;
      $display("FAIL load hex=%h sel=%b exp hex=%h sel=0000", hex, set_sel, exp_hex(v));
    end
  endtask

  // Run for exactly n ticks (stop press lands mid-period) and compare against the model
  task automatic run_ticks(input int n, input logic m);
    int  w, exp_v;
    bit  dead, exp_alarm;
    w = cur_val;
    dead = m && (w == 0);
    mode = m;
    press(0);
    checks++;
    if (running !== !dead) begin
      errors++; $display("FAIL run_start running=%b exp %b", running, !dead);
    end
    for (int c = 0; c < 10*n - 10; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
    end
    mode = m;
    exp_alarm = m && !dead && (w <= n - 1);
    checks++;
    if (alarm !== exp_alarm || running !== (!dead && !exp_alarm)) begin
      errors++;
      $display("FAIL run_mid alarm=%b running=%b exp %b %b", alarm, running, exp_alarm, !dead && !exp_alarm);
    end
    press(0);
    if (dead) exp_v = 0;
    else if (!m) exp_v = (w + n) % 10000;
    else if (n >= w) exp_v = 0;
    else exp_v = w - n;
    checks++;
    if (hex !== exp_hex(exp_v) || running !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL run_end v0=%0d n=%0d m=%b hex=%h run=%b al=%b exp hex=%h", w, n, m, hex, running, alarm, exp_hex(exp_v));
    end
    cur_val = exp_v;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (hex !== {4{7'b1000000}}) begin errors++; $display("FAIL reset_hex got %h exp %h", hex, {4{7'b1000000}}); end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
    checks++;
    if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got %b exp 0", alarm); end
    checks++;
    if (set_sel !== 4'd0) begin errors++; $display("FAIL reset_sel got %b exp 0000", set_sel); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    cur_val = 0;
  endtask

  task automatic test_count_up();
    do_reset();
    mode = 1'b0;
    press(0);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL up_running got %b exp 1", running); end
    repeat (1220) @(negedge clk);
    press(0);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL up_stopped got %b exp 0", running); end
    checks++;
    if (hex !== exp_hex(123)) begin errors++; $display("FAIL up_value got %h exp %h", hex, exp_hex(123)); end
    checks++;
    if (hex[6:0] !== 7'b0110000) begin errors++; $display("FAIL up_digit0 got %b exp 0110000", hex[6:0]); end
    cur_val = 123;
  endtask

  task automatic test_set();
    logic [3:0] exp_sel;
    do_reset();
    press(1);
    checks++;
    if (set_sel !== 4'b0001) begin errors++; $display("FAIL set_enter got %b exp 0001", set_sel); end
    press(0);
    checks++;
    if (set_sel !== 4'b0001 || running !== 1'b0) begin
      errors++; $display("FAIL set_start_ignored sel=%b run=%b exp 0001 0", set_sel, running);
    end
    repeat (11) press(2);
    checks++;
    if (hex !== exp_hex(1)) begin errors++; $display("FAIL set_mod10 got %h exp %h", hex, exp_hex(1)); end
    for (int i = 1; i <= DIGITS; i++) begin
      press(1);
      exp_sel = (i < DIGITS) ? 4'(1 << i) : 4'd0;
      checks++;
      if (set_sel !== exp_sel) begin errors++; $display("FAIL set_ptr%0d got %b exp %b", i, set_sel, exp_sel); end
    end
    cur_val = 1;
  endtask

  task automatic test_wrap();
    do_reset();
    load_value(9999);
    mode = 1'b0;
    press(0);
    repeat (5) @(negedge clk);
    checks++;
    if (hex !== exp_hex(0) || running !== 1'b1) begin
      errors++; $display("FAIL wrap hex=%h run=%b exp %h 1", hex, running, exp_hex(0));
    end
    do_reset();
  endtask

  task automatic test_countdown();
    do_reset();
    load_value(2);
    mode = 1'b1;
    press(0);
    repeat (20) @(negedge clk);
    checks++;
    if (alarm !== 1'b1 || running !== 1'b0 || hex !== exp_hex(0)) begin
      errors++; $display("FAIL down_alarm al=%b run=%b hex=%h exp 1 0 %h", alarm, running, hex, exp_hex(0));
    end
    press(2);
    checks++;
    if (alarm !== 1'b0 || running !== 1'b0 || set_sel !== 4'd0) begin
      errors++; $display("FAIL alarm_clear al=%b run=%b sel=%b exp 0 0 0000", alarm, running, set_sel);
    end
    press(0);
    checks++;
    if (running !== 1'b0 || alarm !== 1'b0) begin
      errors++; $display("FAIL down_zero_start run=%b al=%b exp 0 0", running, alarm);
    end
    mode = 1'b0;
    cur_val = 0;
  endtask

  task automatic test_glitch_reset();
    do_reset();
    start_n = 1'b0;
    repeat (2) @(negedge clk);
    start_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL glitch got running=%b exp 0", running); end
    mode = 1'b0;
    press(0);
    repeat (565) @(negedge clk);
    checks++;
    if (hex !== exp_hex(57) || running !== 1'b1) begin
      errors++; $display("FAIL pre_reset hex=%h run=%b exp %h 1", hex, running, exp_hex(57));
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (hex !== exp_hex(0) || running !== 1'b0) begin
      errors++; $display("FAIL async_reset hex=%h run=%b exp %h 0", hex, running, exp_hex(0));
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    cur_val = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      load_value($urandom_range(0, 9999));
      run_ticks($urandom_range(1, 40), 1'($urandom_range(0, 1)));
    end
    load_value($urandom_range(1, 15));
    run_ticks(20, 1'b1);
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    do_reset();
    mode = 1'b0;
    press(0);
    repeat (389) @(negedge clk);
    press(3);
    checks++;
    if (hex !== exp_hex(40) || running !== 1'b1) begin
      errors++; $display("FAIL lap_freeze hex=%h run=%b exp %h 1", hex, running, exp_hex(40));
    end
    repeat (200) @(negedge clk);
    checks++;
    if (hex !== exp_hex(40)) begin errors++; $display("FAIL lap_hold got %h exp %h", hex, exp_hex(40)); end
    press(3);
    checks++;
    if (hex !== exp_hex(62)) begin errors++; $display("FAIL lap_live got %h exp %h", hex, exp_hex(62)); end
    press(0);
    checks++;
    if (hex !== exp_hex(63) || running !== 1'b0) begin
      errors++; $display("FAIL lap_stop hex=%h run=%b exp %h 0", hex, running, exp_hex(63));
    end
    cur_val = 63;
  endtask
`endif

  initial begin
    rstn = 1'b0;
    start_n = 1'b1; set_n = 1'b1; change_n = 1'b1; lap_n = 1'b1; mode = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_count_up();
    test_set();
    test_wrap();
    test_countdown();
    test_glitch_reset();
    test_random();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
